// File: rtl/onchip_memory_copy_master.sv
// Avalon-MM master that fills or copies word blocks in a single-port on-chip memory
// with read latency 1. One command at a time; all outputs except m_clken are registered.
module onchip_memory_copy_master #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LEN_W-1:0]    words_done,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic                m_clken
);

  typedef enum logic [2:0] {StIdle, StFill, StCpRd, StCpWait, StCpWr, StFin} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   pattern_q;
  logic [DATA_W/8-1:0] be_q;

  logic [ADDR_W-1:0]   src_addr;
  logic [ADDR_W-1:0]   dst_addr;
  logic                fin_now;

  assign m_clken = 1'b1;

  // words_done doubles as the word index; the sum truncates so addresses wrap.
  always_comb begin
    src_addr = src_q + words_done[ADDR_W-1:0];
    dst_addr = dst_q + words_done[ADDR_W-1:0];
    fin_now  = (((state_q == StFill) || (state_q == StCpWr)) && (words_done == len_q)) ||
               ((state_q != StIdle) && (state_q != StFin) && abort);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      pattern_q    <= '0;
      be_q         <= '0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      words_done   <= '0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
    end else if (fin_now) begin
      // The access presented this cycle completes; nothing further is issued.
      state_q      <= StFin;
      done         <= 1'b1;
      busy         <= 1'b0;
      aborted      <= abort;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            src_q      <= cmd_src;
            dst_q      <= cmd_dst;
            len_q      <= cmd_len;
            pattern_q  <= cmd_pattern;
            be_q       <= cmd_byteenable;
            cmd_ready  <= 1'b0;
            words_done <= '0;
            aborted    <= 1'b0;
            if (cmd_len == '0) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else if (!cmd_op) begin
              state_q      <= StFill;
              busy         <= 1'b1;
              m_chipselect <= 1'b1;
              m_write      <= 1'b1;
              m_address    <= cmd_dst;
              m_writedata  <= cmd_pattern;
              m_byteenable <= cmd_byteenable;
              words_done   <= LEN_W'(1);
            end else begin
              state_q      <= StCpRd;
              busy         <= 1'b1;
              m_chipselect <= 1'b1;
              m_write      <= 1'b0;
              m_address    <= cmd_src;
              m_byteenable <= '1;
            end
          end
        end
        StFill: begin
          m_address  <= dst_addr;
          m_writedata <= pattern_q;
          m_byteenable <= be_q;
          words_done <= words_done + LEN_W'(1);
        end
        StCpRd: begin
          state_q      <= StCpWait;
          m_chipselect <= 1'b0;
        end
        StCpWait: begin
          state_q      <= StCpWr;
          m_chipselect <= 1'b1;
          m_write      <= 1'b1;
          m_address    <= dst_addr;
          m_writedata  <= m_readdata;
          m_byteenable <= '1;
          words_done   <= words_done + LEN_W'(1);
        end
        StCpWr: begin
          state_q      <= StCpRd;
          m_write      <= 1'b0;
          m_address    <= src_addr;
          m_byteenable <= '1;
        end
        StFin: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
          aborted   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_memory_copy_master.sv
// Bench for onchip_memory_copy_master: behavioural latency-1 memory plus an access
// scoreboard of expected (cycle, address, data, byteenable) entries.
module tb_onchip_memory_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [13:0] cmd_src = '0;
  logic [13:0] cmd_dst = '0;
  logic [14:0] cmd_len = '0;
  logic [31:0] cmd_pattern = '0;
  logic [3:0]  cmd_byteenable = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [14:0] words_done;
  logic [13:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
  logic        m_clken;

  onchip_memory_copy_master dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_src       (cmd_src),
    .cmd_dst       (cmd_dst),
    .cmd_len       (cmd_len),
    .cmd_pattern   (cmd_pattern),
    .cmd_byteenable(cmd_byteenable),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .words_done    (words_done),
    .m_address     (m_address),
    .m_byteenable  (m_byteenable),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_clken       (m_clken)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [16384];
  always @(posedge clk) begin
    if (m_chipselect && !m_write) m_readdata <= mem[m_address];
    if (m_chipselect && m_write)
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
  end

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } acc_t;
  acc_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (m_chipselect === 1'b1) begin
      acc_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL access: got unexpected wr=%0b addr=%h cycle %0d, required no access",
                 m_write, m_address, cyc);
      end else begin
        e = exp_q.pop_front();
        if (m_write !== e.wr || m_address !== e.addr || m_byteenable !== e.be ||
            (e.wr && m_writedata !== e.data) || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL access: got wr=%0b addr=%h data=%h be=%h cyc=%0d, required wr=%0b addr=%h data=%h be=%h cyc=%0d",
                   m_write, m_address, m_writedata, m_byteenable, cyc,
                   e.wr, e.addr, e.data, e.be, e.cyc);
        end
      end
    end
  end

  function automatic acc_t mk(bit wr, logic [13:0] a, logic [31:0] d, logic [3:0] be, int c);
    acc_t e;
    e.wr = wr; e.addr = a; e.data = d; e.be = be; e.cyc = c;
    return e;
  endfunction

  task automatic issue(input logic op, input logic [13:0] src, input logic [13:0] dst,
                       input logic [14:0] len, input logic [31:0] pat, input logic [3:0] be,
                       output int t);
    @(negedge clk);
    for (int k = 0; k < 50 && cmd_ready !== 1'b1; k++) @(negedge clk);
    if (cmd_ready !== 1'b1) begin
      $display("FAIL issue: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
      $fatal(1);
    end
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len;
    cmd_pattern = pat; cmd_byteenable = be; cmd_valid = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, done, aborted, m_chipselect, m_write} !== 6'b0 ||
        words_done !== '0 || m_address !== '0 || m_byteenable !== '0 || m_writedata !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b busy=%b done=%b ab=%b cs=%b wr=%b wd=%0d addr=%h be=%h data=%h, required all 0",
               cmd_ready, busy, done, aborted, m_chipselect, m_write, words_done,
               m_address, m_byteenable, m_writedata);
    end
    n_checks++;
    if (m_clken !== 1'b1) begin
      n_fail++;
      $display("FAIL clken: got %b, required 1", m_clken);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_fill();
    int t; bit seen;
    issue(1'b0, 14'h0, 14'h0010, 15'd4, 32'hDEADBEEF, 4'hF, t);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 14'(14'h10 + i), 32'hDEADBEEF, 4'hF, t + 1 + i));
    wait_done(seen);
    n_checks++;
    if (!seen || cyc != t + 5 || aborted !== 1'b0 || words_done !== 15'd4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_done: got seen=%0b cyc=%0d ab=%b wd=%0d busy=%b, required cyc=%0d ab=0 wd=4 busy=0",
               seen, cyc, aborted, words_done, busy, t + 5);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_ready: got rdy=%b done=%b, required rdy=1 done=0", cmd_ready, done);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_accesses: got %0d missing accesses, required 0", exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[14'h10 + i] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL fill_readback[%0d]: got %h, required deadbeef", i, mem[14'h10 + i]);
      end
    end
  endtask

  task automatic test_byteenable();
    int t; bit seen;
    mem[14'h20] = 32'hA5A5A5A5;
    issue(1'b0, 14'h0, 14'h0020, 15'd1, 32'h12345678, 4'h5, t);
    exp_q.push_back(mk(1, 14'h20, 32'h12345678, 4'h5, t + 1));
    wait_done(seen);
    n_checks++;
    if (!seen || cyc != t + 2 || words_done !== 15'd1) begin
      n_fail++;
      $display("FAIL be_done: got seen=%0b cyc=%0d wd=%0d, required cyc=%0d wd=1",
               seen, cyc, words_done, t + 2);
    end
    @(negedge clk);
    n_checks++;
    if (mem[14'h20] !== 32'hA534A578) begin
      n_fail++;
      $display("FAIL be_readback: got %h, required a534a578", mem[14'h20]);
    end
  endtask

  task automatic test_copy();
    int t; bit seen;
    logic [31:0] src_val [4];
    src_val[0] = 32'h11111111; src_val[1] = 32'h22222222;
    src_val[2] = 32'h33333333; src_val[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) mem[14'h100 + i] = src_val[i];
    issue(1'b1, 14'h0100, 14'h0200, 15'd4, 32'h0, 4'h0, t);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(0, 14'(14'h100 + i), 32'h0, 4'hF, t + 1 + 3 * i));
      exp_q.push_back(mk(1, 14'(14'h200 + i), src_val[i], 4'hF, t + 3 + 3 * i));
    end
    wait_done(seen);
    n_checks++;
    if (!seen || cyc != t + 13 || aborted !== 1'b0 || words_done !== 15'd4) begin
      n_fail++;
      $display("FAIL copy_done: got seen=%0b cyc=%0d ab=%b wd=%0d, required cyc=%0d ab=0 wd=4",
               seen, cyc, aborted, words_done, t + 13);
    end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL copy_accesses: got %0d missing accesses, required 0", exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[14'h200 + i] !== src_val[i]) begin
        n_fail++;
        $display("FAIL copy_readback[%0d]: got %h, required %h", i, mem[14'h200 + i], src_val[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int t; bit seen;
    logic [13:0] a;
    issue(1'b0, 14'h0, 14'h3FFE, 15'd4, 32'hCAFEF00D, 4'hF, t);
    a = 14'h3FFE;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1, a, 32'hCAFEF00D, 4'hF, t + 1 + i));
      a = a + 14'd1;
    end
    wait_done(seen);
    n_checks++;
    if (!seen || cyc != t + 5 || words_done !== 15'd4) begin
      n_fail++;
      $display("FAIL wrap_done: got seen=%0b cyc=%0d wd=%0d, required cyc=%0d wd=4",
               seen, cyc, words_done, t + 5);
    end
    @(negedge clk);
    n_checks++;
    if (mem[14'h3FFF] !== 32'hCAFEF00D || mem[14'h0001] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL wrap_readback: got %h %h, required cafef00d cafef00d", mem[14'h3FFF], mem[14'h0001]);
    end
  endtask

  task automatic test_len0();
    int t; bit seen;
    issue(1'b1, 14'h0100, 14'h0500, 15'd0, 32'h0, 4'h0, t);
    wait_done(seen);
    n_checks++;
    if (!seen || cyc != t + 1 || aborted !== 1'b0 || words_done !== 15'd0) begin
      n_fail++;
      $display("FAIL len0_done: got seen=%0b cyc=%0d ab=%b wd=%0d, required cyc=%0d ab=0 wd=0",
               seen, cyc, aborted, words_done, t + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_fill();
    int t;
    issue(1'b0, 14'h0, 14'h1000, 15'd100, 32'h5A5A0001, 4'hF, t);
    for (int i = 0; i < 10; i++) exp_q.push_back(mk(1, 14'(14'h1000 + i), 32'h5A5A0001, 4'hF, t + 1 + i));
    for (int k = 0; k < 20 && cyc != t + 10; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || words_done !== 15'd10 || cyc != t + 11) begin
      n_fail++;
      $display("FAIL abort_fill: got done=%b ab=%b wd=%0d cyc=%0d, required done=1 ab=1 wd=10 cyc=%0d",
               done, aborted, words_done, cyc, t + 11);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || mem[14'h1009] !== 32'h5A5A0001 || mem[14'h100A] !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_fill_mem: got missing=%0d m9=%h m10=%h, required 0 5a5a0001 0",
               exp_q.size(), mem[14'h1009], mem[14'h100A]);
      exp_q.delete();
    end
  endtask

  task automatic test_abort_copy();
    int t;
    issue(1'b1, 14'h0100, 14'h0600, 15'd4, 32'h0, 4'h0, t);
    exp_q.push_back(mk(0, 14'h100, 32'h0, 4'hF, t + 1));
    exp_q.push_back(mk(1, 14'h600, 32'h11111111, 4'hF, t + 3));
    exp_q.push_back(mk(0, 14'h101, 32'h0, 4'hF, t + 4));
    for (int k = 0; k < 20 && cyc != t + 5; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || words_done !== 15'd1 || cyc != t + 6) begin
      n_fail++;
      $display("FAIL abort_copy: got done=%b ab=%b wd=%0d cyc=%0d, required done=1 ab=1 wd=1 cyc=%0d",
               done, aborted, words_done, cyc, t + 6);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || mem[14'h601] !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_copy_mem: got missing=%0d m601=%h, required 0 0", exp_q.size(), mem[14'h601]);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int t, dc; bit seen;
    issue(1'b1, 14'h0100, 14'h0300, 15'd4, 32'h0, 4'h0, t);
    exp_q.push_back(mk(0, 14'h100, 32'h0, 4'hF, t + 1));
    exp_q.push_back(mk(1, 14'h300, 32'h11111111, 4'hF, t + 3));
    exp_q.push_back(mk(0, 14'h101, 32'h0, 4'hF, t + 4));
    for (int k = 0; k < 20 && cyc != t + 5; k++) @(negedge clk);
    dc = done_count;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, done, aborted, m_chipselect, m_write} !== 6'b0 ||
        words_done !== '0 || m_address !== '0 || m_byteenable !== '0 || m_writedata !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_values: got rdy=%b busy=%b done=%b ab=%b cs=%b wr=%b wd=%0d addr=%h, required all 0",
               cmd_ready, busy, done, aborted, m_chipselect, m_write, words_done, m_address);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_count != dc || exp_q.size() != 0 || mem[14'h301] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got done_pulses=%0d missing=%0d m301=%h, required 0 0 0",
               done_count - dc, exp_q.size(), mem[14'h301]);
      exp_q.delete();
    end
    issue(1'b0, 14'h0, 14'h0700, 15'd3, 32'h0BADF00D, 4'hF, t);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 14'(14'h700 + i), 32'h0BADF00D, 4'hF, t + 1 + i));
    wait_done(seen);
    n_checks++;
    if (!seen || cyc != t + 4 || aborted !== 1'b0 || words_done !== 15'd3) begin
      n_fail++;
      $display("FAIL post_reset_fill: got seen=%0b cyc=%0d ab=%b wd=%0d, required cyc=%0d ab=0 wd=3",
               seen, cyc, aborted, words_done, t + 4);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    test_reset();
    test_fill();
    test_byteenable();
    test_copy();
    test_wrap();
    test_len0();
    test_abort_fill();
    test_abort_copy();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
